or_nor_select_decoder: RTL

OR_NOR_SELECT_DECODER -- requirements
Module: or_nor_select_decoder

---
 rtl/or_nor_pkg.sv | 13 +
 rtl/or_nor_select_infer.sv | 12 +
 rtl/or_nor_select_decoder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/or_nor_pkg.sv
// Shared FSM encoding and select-value constants for the OR/NOR select decoder.
package or_nor_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StPublish = 2'd2
  } state_e;

  localparam logic SEL_OR  = 1'b0;
  localparam logic SEL_NOR = 1'b1;

endpackage

// File: rtl/or_nor_select_infer.sv
// Infers the select of an OR/NOR selectable unit from one observed sample:
// the observed output differs from a|b exactly when the unit is in NOR mode.
module or_nor_select_infer (
  input  logic a,
  input  logic b,
  input  logic out_obs,
  output logic s
);

  assign s = out_obs ^ (a | b);

endmodule

// File: rtl/or_nor_select_decoder.sv
// Recovers the OR/NOR select of an observed unit by majority over a window of samples.
// Optional mismatch_cnt output is compiled in with OR_NOR_MISMATCH_CNT_EN.
module or_nor_select_decoder
  import or_nor_pkg::*;
#(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             out_obs,
  output logic             busy,
  output logic             done,
  output logic             sel_decided,
  output logic             consistent,
`ifdef OR_NOR_MISMATCH_CNT_EN
  output logic [CNT_W-1:0] mismatch_cnt,
`endif
  output logic [CNT_W-1:0] ones_cnt
);

  state_e           state_q;
  logic [CNT_W-1:0] sample_q;
  logic [CNT_W-1:0] ones_q;
  logic             ref_q;
  logic             flag_q;

  logic             s;
  logic             first;
  logic             last;
  logic             hit;
  logic             flag_next;
  logic [CNT_W-1:0] ones_next;
  logic [CNT_W:0]   twice_ones;
  logic             sel_next;

  or_nor_select_infer u_infer (
    .a       (a),
    .b       (b),
    .out_obs (out_obs),
    .s       (s)
  );

  always_comb begin
    first      = (sample_q == '0);
    last       = (sample_q == CNT_W'(WINDOW - 1));
    hit        = !first && (s != ref_q);
    flag_next  = flag_q & ~hit;
    ones_next  = ones_q + CNT_W'(s);
    twice_ones = {ones_next, 1'b0};
    // Strict majority; a tie resolves to OR.
    sel_next   = (twice_ones > (CNT_W + 1)'(WINDOW)) ? SEL_NOR : SEL_OR;
  end

  assign in_ready = (state_q == StCollect);
  assign busy     = (state_q != StIdle);

`ifdef OR_NOR_MISMATCH_CNT_EN
  logic [CNT_W-1:0] mism_q;
  logic [CNT_W-1:0] mism_next;
  assign mism_next = mism_q + CNT_W'(hit);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sample_q     <= '0;
      ones_q       <= '0;
      ref_q        <= 1'b0;
      flag_q       <= 1'b0;
      done         <= 1'b0;
      sel_decided  <= 1'b0;
      consistent   <= 1'b0;
      ones_cnt     <= '0;
`ifdef OR_NOR_MISMATCH_CNT_EN
      mism_q       <= '0;
      mismatch_cnt <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            state_q  <= StCollect;
            sample_q <= '0;
            ones_q   <= '0;
            ref_q    <= 1'b0;
            flag_q   <= 1'b1;
`ifdef OR_NOR_MISMATCH_CNT_EN
            mism_q   <= '0;
`endif
          end
        end
        StCollect: begin
          if (in_valid) begin
            sample_q <= sample_q + 1'b1;
            ones_q   <= ones_next;
            flag_q   <= flag_next;
            if (first) begin
              ref_q <= s;
            end
`ifdef OR_NOR_MISMATCH_CNT_EN
            mism_q <= mism_next;
`endif
            // Publish registers load here so they are visible during the PUBLISH cycle.
            if (last) begin
              state_q     <= StPublish;
              done        <= 1'b1;
              sel_decided <= sel_next;
              consistent  <= flag_next;
              ones_cnt    <= ones_next;
`ifdef OR_NOR_MISMATCH_CNT_EN
              mismatch_cnt <= mism_next;
`endif
            end
          end
        end
        StPublish: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
